// File: rtl/alu_out_stage.sv
// alu_out_stage: execute stage that sits after the A/B operand registers.
// Single-cycle ALU ops register into ALUOut/zero/overflow. MULTU/DIVU
// iterate one bit per cycle and write HI/LO when they finish.
//
// Ports:
//   clk, reset           clock (rising edge), asynchronous active-high reset
//   A, B                 operands from Areg/Breg
//   alu_op, start        operation select, sampled with start (ignored while busy)
//   ALUOut, zero         registered single-cycle result and its zero flag
//   overflow             registered signed overflow (ADD/SUB only)
//   HI, LO               product high/low word, or remainder/quotient
//   busy                 high while MULTU/DIVU iterates
//   done                 one-cycle completion pulse
module alu_out_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       alu_op,
  input  logic             start,
  output logic [WIDTH-1:0] ALUOut,
  output logic             zero,
  output logic             overflow,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  typedef enum logic [3:0] {
    OP_AND  = 4'd0,  OP_OR   = 4'd1,  OP_ADD  = 4'd2,  OP_XOR  = 4'd3,
    OP_NOR  = 4'd4,  OP_SLL  = 4'd5,  OP_SUB  = 4'd6,  OP_SLT  = 4'd7,
    OP_SLTU = 4'd8,  OP_SRL  = 4'd9,  OP_SRA  = 4'd10, OP_MULTU = 4'd11,
    OP_DIVU = 4'd12, OP_MFHI = 4'd13, OP_MFLO = 4'd14, OP_ILL  = 4'd15
  } op_t;

  state_t           state, state_next;
  op_t              op;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] w_hi, w_lo, w_op;
  logic [WIDTH-1:0] iter_hi, iter_lo;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             accept, long_op;
  logic [4:0]       shamt;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_r, div_d;

  assign op      = op_t'(alu_op);
  assign accept  = start && (state == IDLE);
  assign long_op = (op == OP_MULTU) || (op == OP_DIVU);
  assign shamt   = A[4:0];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept && op == OP_MULTU)     state_next = MUL;
        else if (accept && op == OP_DIVU) state_next = DIV;
      end
      MUL, DIV: if (count == '0) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = (state != IDLE);
  end

  // Single-cycle ALU
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op)
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_ADD: begin
        alu_res = A + B;
        alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (alu_res[WIDTH-1] != A[WIDTH-1]);
      end
      OP_XOR:  alu_res = A ^ B;
      OP_NOR:  alu_res = ~(A | B);
      OP_SLL:  alu_res = B << shamt;
      OP_SUB: begin
        alu_res = A - B;
        alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (alu_res[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLT:  alu_res = WIDTH'($signed(A) < $signed(B));
      OP_SLTU: alu_res = WIDTH'(A < B);
      OP_SRL:  alu_res = B >> shamt;
      OP_SRA:  alu_res = WIDTH'($signed(B) >>> shamt);
      OP_MFHI: alu_res = HI;
      OP_MFLO: alu_res = LO;
      default: alu_res = '0;
    endcase
  end

  // One iteration step. The work registers are shared by both ops:
  // MUL keeps {partial product high, multiplier shifting out of w_lo};
  // DIV keeps {partial remainder, dividend shifting into quotient}.
  always_comb begin
    mul_sum = {1'b0, w_hi} + (w_lo[0] ? {1'b0, w_op} : '0);
    div_r   = {w_hi, w_lo[WIDTH-1]};
    div_d   = div_r - {1'b0, w_op};
    iter_hi = w_hi;
    iter_lo = w_lo;
    if (state == MUL) begin
      iter_hi = mul_sum[WIDTH:1];
      iter_lo = {mul_sum[0], w_lo[WIDTH-1:1]};
    end else if (state == DIV) begin
      // Borrow out (div_d[WIDTH]) means restore the shifted remainder.
      iter_hi = div_d[WIDTH] ? div_r[WIDTH-1:0] : div_d[WIDTH-1:0];
      iter_lo = {w_lo[WIDTH-2:0], ~div_d[WIDTH]};
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ALUOut   <= '0;
      zero     <= 1'b1;
      overflow <= 1'b0;
      HI       <= '0;
      LO       <= '0;
      done     <= 1'b0;
      count    <= '0;
      w_hi     <= '0;
      w_lo     <= '0;
      w_op     <= '0;
    end else begin
      done <= 1'b0;
      if (accept && !long_op) begin
        ALUOut   <= alu_res;
        zero     <= (alu_res == '0);
        overflow <= alu_ovf;
        done     <= 1'b1;
      end
      if (accept && long_op) begin
        w_hi  <= '0;
        w_lo  <= A;
        w_op  <= B;
        count <= CW'(WIDTH - 1);
      end
      if (state != IDLE) begin
        w_hi  <= iter_hi;
        w_lo  <= iter_lo;
        count <= count - 1'b1;
        if (count == '0) begin
          HI   <= iter_hi;
          LO   <= iter_lo;
          done <= 1'b1;
        end
      end
    end
  end

endmodule
